// File: rtl/neuron_tbl_pkg.sv
// Shared types for the programmable truth-table neuron: FSM states, default widths, fan-in address type.
package neuron_tbl_pkg;
    localparam int NEURON_IN_BITS  = 8;
    localparam int NEURON_OUT_BITS = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

    typedef logic [NEURON_IN_BITS-1:0] fanin_addr_t;
endpackage

// File: rtl/neuron_tbl_ram.sv
// DEPTH x OUT_BITS distributed table: one sync write port and one registered read port; 1-cycle read latency, no stall.
// With NEURON_TBL_READBACK_EN a second registered read port serves config readback independently.
module neuron_tbl_ram
    import neuron_tbl_pkg::*;
#(
    parameter int IN_BITS  = NEURON_IN_BITS,
    parameter int OUT_BITS = NEURON_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [IN_BITS-1:0]  wr_addr_i,
    input  logic [OUT_BITS-1:0] wr_data_i,
    input  logic                rd_en_i,
    input  logic [IN_BITS-1:0]  rd_addr_i,
    output logic [OUT_BITS-1:0] rd_data_o
`ifdef NEURON_TBL_READBACK_EN
    ,
    input  logic                rb_en_i,
    input  logic [IN_BITS-1:0]  rb_addr_i,
    output logic [OUT_BITS-1:0] rb_data_o
`endif
);
    localparam int DEPTH = 2 ** IN_BITS;

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BITS-1:0] mem_q [DEPTH];
    logic [OUT_BITS-1:0] rd_data_q;

    // Table storage is deliberately not reset; only the read registers are.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

`ifdef NEURON_TBL_READBACK_EN
    logic [OUT_BITS-1:0] rb_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_data_q <= '0;
        end else if (rb_en_i) begin
            rb_data_q <= mem_q[rb_addr_i];
        end
    end

    assign rb_data_o = rb_data_q;
`endif
endmodule

// File: rtl/neuron_table_loader.sv
// Runtime-loadable LUT neuron: config stream fills the table, then lookups return 1 cycle after accept; no output backpressure.
// Config beats are accepted only in LOAD, lookups only in RUN. NEURON_TBL_READBACK_EN adds a readback port.
module neuron_table_loader
    import neuron_tbl_pkg::*;
#(
    parameter int IN_BITS  = NEURON_IN_BITS,
    parameter int OUT_BITS = NEURON_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                loaded,
    output logic                err_len
`ifdef NEURON_TBL_READBACK_EN
    ,
    input  logic                rb_req,
    input  logic [IN_BITS-1:0]  rb_addr,
    output logic                rb_valid,
    output logic [OUT_BITS-1:0] rb_data
`endif
);
    state_e             state_q, state_d;
    logic [IN_BITS-1:0] wr_addr_q, wr_addr_d;
    logic               loaded_q, loaded_d;
    logic               err_q, err_d;
    logic               out_vld_q;
    logic               we;
    logic               rd_en;

    assign cfg_ready = (state_q == ST_LOAD);
    assign in_ready  = (state_q == ST_RUN);
    assign rd_en     = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        loaded_d  = loaded_q;
        err_d     = err_q;
        we        = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (cfg_start) begin
                    state_d   = ST_LOAD;
                    wr_addr_d = '0;
                    loaded_d  = 1'b0;
                    err_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                // A restart wins over any beat presented in the same cycle.
                if (cfg_start) begin
                    wr_addr_d = '0;
                    err_d     = 1'b0;
                end else if (cfg_valid) begin
                    we = 1'b1;
                    if (wr_addr_q == '1) begin
                        if (cfg_last) begin
                            state_d  = ST_RUN;
                            loaded_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (cfg_last) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
            out_vld_q <= rd_en;
        end
    end

    assign out_valid = out_vld_q;
    assign loaded    = loaded_q;
    assign err_len   = err_q;

`ifdef NEURON_TBL_READBACK_EN
    logic rb_en;
    logic rb_vld_q;

    assign rb_en = rb_req & (state_q != ST_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_vld_q <= 1'b0;
        end else begin
            rb_vld_q <= rb_en;
        end
    end

    assign rb_valid = rb_vld_q;
`endif

    neuron_tbl_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (cfg_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (in_data),
        .rd_data_o (out_data)
`ifdef NEURON_TBL_READBACK_EN
        ,
        .rb_en_i   (rb_en),
        .rb_addr_i (rb_addr),
        .rb_data_o (rb_data)
`endif
    );
endmodule
